// File: rtl/mult_hilo_ctrl_if.sv
// Bundles the EX-stage request side and the iterative multiplier side of the HI/LO controller.
// Latency: wiring only. Backpressure: none here; busy is carried as a plain signal.
// slave = controller view, master = driver/stub view.
interface mult_hilo_ctrl_if #(parameter int NBIT = 32);
    logic              start;
    logic [1:0]        op;
    logic [NBIT-1:0]   rs_data;
    logic [NBIT-1:0]   rt_data;
    logic              flush;
    logic              busy;
    logic              err;
    logic [NBIT-1:0]   hi;
    logic [NBIT-1:0]   lo;
    logic [NBIT-1:0]   mul_a;
    logic [NBIT-1:0]   mul_b;
    logic              mul_work;
    logic              mul_sign;
    logic [2*NBIT-1:0] mul_prod;
    logic              mul_done;

    modport slave (
        input  start, op, rs_data, rt_data, flush, mul_prod, mul_done,
        output busy, err, hi, lo, mul_a, mul_b, mul_work, mul_sign
    );

    modport master (
        output start, op, rs_data, rt_data, flush, mul_prod, mul_done,
        input  busy, err, hi, lo, mul_a, mul_b, mul_work, mul_sign
    );
endinterface

// File: rtl/mult_hilo_ctrl.sv
// Sequences MULT/MULTU through the iterative multiplier into HI/LO; also executes MTHI/MTLO.
// Latency: MTHI/MTLO 1 edge; multiply = multiplier latency + 2 edges (33 with the 31-delay unit).
// Backpressure: busy is high throughout RUN; start is ignored then and upstream must stall on it.
module mult_hilo_ctrl #(
    parameter int NBIT    = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    mult_hilo_ctrl_if.slave   bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_MTHI  = 2'b10,
        OP_MTLO  = 2'b11
    } op_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic            ld_mul;
    logic            tmo;
    logic [NBIT-1:0] hi_nxt;
    logic [NBIT-1:0] lo_nxt;

    assign bus.busy = (state == RUN);

    always_comb begin
        state_nxt = state;
        ld_mul    = 1'b0;
        tmo       = 1'b0;
        hi_nxt    = bus.hi;
        lo_nxt    = bus.lo;
        case (state)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    case (op_t'(bus.op))
                        OP_MULT, OP_MULTU: begin
                            ld_mul    = 1'b1;
                            state_nxt = RUN;
                        end
                        OP_MTHI: hi_nxt = bus.rs_data;
                        OP_MTLO: lo_nxt = bus.rs_data;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                // Flush outranks a coincident done so a squashed op never reaches HI/LO.
                if (bus.flush) begin
                    state_nxt = IDLE;
                end else if (bus.mul_done) begin
                    hi_nxt    = bus.mul_prod[2*NBIT-1:NBIT];
                    lo_nxt    = bus.mul_prod[NBIT-1:0];
                    state_nxt = IDLE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    tmo       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            bus.hi       <= '0;
            bus.lo       <= '0;
            bus.mul_a    <= '0;
            bus.mul_b    <= '0;
            bus.mul_work <= 1'b0;
            bus.mul_sign <= 1'b0;
            bus.err      <= 1'b0;
        end else begin
            state        <= state_nxt;
            bus.hi       <= hi_nxt;
            bus.lo       <= lo_nxt;
            bus.err      <= tmo;
            // RUN always exits through IDLE, which guarantees a work-low edge between ops.
            bus.mul_work <= (state_nxt == RUN);
            if (ld_mul) begin
                bus.mul_a    <= bus.rs_data;
                bus.mul_b    <= bus.rt_data;
                bus.mul_sign <= ~bus.op[0];
                cnt          <= '0;
            end else if (state == RUN) begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Directed bench for mult_hilo_ctrl with a behavioural iterative multiplier stub.
module tb_mult_hilo_ctrl;
    localparam int LAT = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mult_hilo_ctrl_if #(.NBIT(32)) bus();

    mult_hilo_ctrl #(.NBIT(32), .TIMEOUT(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    bit   no_done = 1'b0;
    logic [7:0] mcnt;
    int   n, unstable;

    function automatic logic [63:0] mprod(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0] ea, eb;
        ea = s ? {{32{a[31]}}, a} : {32'h0, a};
        eb = s ? {{32{b[31]}}, b} : {32'h0, b};
        return ea * eb;
    endfunction

    // Multiplier stub: done rises LAT edges after work is first seen, then holds until work drops.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcnt         <= '0;
            bus.mul_done <= 1'b0;
            bus.mul_prod <= '0;
        end else if (!bus.mul_work) begin
            mcnt         <= '0;
            bus.mul_done <= 1'b0;
        end else begin
            mcnt <= mcnt + 8'd1;
            if (mcnt + 8'd1 == 8'(LAT) && !no_done) begin
                bus.mul_done <= 1'b1;
                bus.mul_prod <= mprod(bus.mul_a, bus.mul_b, bus.mul_sign);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start   = 1'b1;
        bus.op      = op;
        bus.rs_data = a;
        bus.rt_data = b;
        @(negedge clk);
        bus.start   = 1'b0;
    endtask

    // Counts busy cycles from the current negedge; flags operand/work changes during RUN.
    task automatic run_busy(output int cyc, output int bad);
        logic [31:0] a0, b0;
        logic        s0;
        cyc = 0;
        bad = 0;
        a0  = bus.mul_a;
        b0  = bus.mul_b;
        s0  = bus.mul_sign;
        while (bus.busy && cyc < 300) begin
            cyc++;
            if (bus.mul_a !== a0 || bus.mul_b !== b0 || bus.mul_sign !== s0 || bus.mul_work !== 1'b1)
                bad++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        bus.start   = 1'b0;
        bus.flush   = 1'b0;
        bus.op      = 2'b00;
        bus.rs_data = '0;
        bus.rt_data = '0;
        @(negedge clk);
        chk("rst_busy", {63'h0, bus.busy}, 64'h0);
        chk("rst_hilo", {bus.hi, bus.lo}, 64'h0);
        chk("rst_mulab", {bus.mul_a, bus.mul_b}, 64'h0);
        chk("rst_ctl", {61'h0, bus.mul_work, bus.mul_sign, bus.err}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: MULTU
        issue(2'b01, 32'hFFFF_FFFF, 32'h0000_0002);
        chk("t1_sign", {63'h0, bus.mul_sign}, 64'h0);
        run_busy(n, unstable);
        chk("t1_busy_cycles", 64'(n), 64'd33);
        chk("t1_hi", {32'h0, bus.hi}, 64'h1);
        chk("t1_lo", {32'h0, bus.lo}, 64'hFFFF_FFFE);
        @(negedge clk);

        // 2: MULT signed
        issue(2'b00, 32'hFFFF_FFFD, 32'h0000_0007);
        chk("t2_sign", {63'h0, bus.mul_sign}, 64'h1);
        chk("t2_mula", {32'h0, bus.mul_a}, 64'hFFFF_FFFD);
        run_busy(n, unstable);
        chk("t2_stable", 64'(unstable), 64'd0);
        chk("t2_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        @(negedge clk);

        // 3: back-to-back, second start in the IDLE cycle right after capture
        issue(2'b00, 32'd5, 32'd6);
        run_busy(n, unstable);
        chk("t3_lo_a", {32'h0, bus.lo}, 64'd30);
        chk("t3_work_gap", {63'h0, bus.mul_work}, 64'h0);
        chk("t3_stale_busy", {63'h0, bus.busy}, 64'h0);
        issue(2'b00, 32'd7, 32'd8);
        chk("t3_work_back", {63'h0, bus.mul_work}, 64'h1);
        run_busy(n, unstable);
        chk("t3_busy_cycles", 64'(n), 64'd33);
        chk("t3_lo_b", {32'h0, bus.lo}, 64'd56);
        @(negedge clk);

        // 4: flush mid-run, then flush coincident with done
        issue(2'b00, 32'd9, 32'd9);
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("t4_busy", {63'h0, bus.busy}, 64'h0);
        chk("t4_work", {63'h0, bus.mul_work}, 64'h0);
        chk("t4_hilo", {bus.hi, bus.lo}, 64'd56);
        repeat (2) @(negedge clk);
        issue(2'b00, 32'd3, 32'd3);
        n = 0;
        while (!bus.mul_done && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("t4_done_seen", {63'h0, bus.mul_done}, 64'h1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("t4c_busy", {63'h0, bus.busy}, 64'h0);
        chk("t4c_hilo", {bus.hi, bus.lo}, 64'd56);
        @(negedge clk);
        bus.flush = 1'b1;
        issue(2'b10, 32'h0000_0055, 32'h0);
        bus.flush = 1'b0;
        chk("t4_flush_start", {32'h0, bus.hi}, 64'h0);

        // 5: MTHI/MTLO in IDLE, MTHI ignored in RUN
        issue(2'b10, 32'hDEAD_BEEF, 32'h0);
        chk("t5_mthi", {bus.hi, bus.lo}, {32'hDEAD_BEEF, 32'd56});
        chk("t5_busy", {63'h0, bus.busy}, 64'h0);
        issue(2'b11, 32'h1234_5678, 32'h0);
        chk("t5_mtlo", {bus.hi, bus.lo}, {32'hDEAD_BEEF, 32'h1234_5678});
        issue(2'b00, 32'd2, 32'd3);
        repeat (5) @(negedge clk);
        issue(2'b10, 32'h0000_AAAA, 32'h0);
        chk("t5_run_mthi", {32'h0, bus.hi}, 64'hDEAD_BEEF);
        chk("t5_run_busy", {63'h0, bus.busy}, 64'h1);
        run_busy(n, unstable);
        chk("t5_prod", {bus.hi, bus.lo}, 64'd6);
        @(negedge clk);

        // 6: timeout with a multiplier that never finishes
        no_done = 1'b1;
        issue(2'b00, 32'd4, 32'd5);
        run_busy(n, unstable);
        chk("t6_busy_cycles", 64'(n), 64'd64);
        chk("t6_err", {63'h0, bus.err}, 64'h1);
        chk("t6_hilo", {bus.hi, bus.lo}, 64'd6);
        @(negedge clk);
        chk("t6_err_pulse", {63'h0, bus.err}, 64'h0);
        chk("t6_idle", {63'h0, bus.busy}, 64'h0);

        // async reset in the middle of RUN
        issue(2'b01, 32'hFFFF_FFFF, 32'h0000_0003);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_run_busy", {63'h0, bus.busy}, 64'h0);
        chk("rst_run_hilo", {bus.hi, bus.lo}, 64'h0);
        chk("rst_run_mulab", {bus.mul_a, bus.mul_b}, 64'h0);
        chk("rst_run_ctl", {61'h0, bus.mul_work, bus.mul_sign, bus.err}, 64'h0);
        @(negedge clk);
        rst_n   = 1'b1;
        no_done = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
